// File: rtl/sorted_reg_bank.v
// sorted_reg_bank: a DEPTH x WIDTH register bank that keeps its contents sorted by single-cycle insertion.
// Entry 0 is the head (minimum, or maximum when DESCEND=1); entries beyond count always read 0.
module sorted_reg_bank #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH*DEPTH-1:0]     all_data
);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic [WIDTH-1:0] pp_data [DEPTH];
    logic [DEPTH-1:0] pp_valid;
    logic [CW-1:0]    pp_count;
    logic [CW-1:0]    pos;
    logic             pop_eff;
    logic             accept;

    function automatic logic goes_before(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic r;
        if (DESCEND) begin
            r = (a > b);
        end else begin
            r = (a < b);
        end
        return r;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == CW'(0));

    // Next-state: pop is applied first, then the insert is placed against the post-pop contents.
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        count_d  = count_q;
        pop_eff  = pop & en & ~empty;
        in_ready = en & (~full | pop);
        accept   = in_valid & in_ready;

        for (int i = 0; i < DEPTH-1; i++) begin
            pp_data[i]  = pop_eff ? data_q[i+1] : data_q[i];
            pp_valid[i] = pop_eff ? valid_q[i+1] : valid_q[i];
        end
        pp_data[DEPTH-1]  = pop_eff ? {WIDTH{1'b0}} : data_q[DEPTH-1];
        pp_valid[DEPTH-1] = pop_eff ? 1'b0 : valid_q[DEPTH-1];
        pp_count          = pop_eff ? (count_q - CW'(1)) : count_q;

        // Scanning downward leaves pos at the lowest qualifying index; equal values never qualify,
        // so a new value lands after its equals.
        pos = pp_count;
        for (int i = DEPTH-1; i >= 0; i--) begin
            pos = (pp_valid[i] && goes_before(in_data, pp_data[i])) ? CW'(i) : pos;
        end

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = {WIDTH{1'b0}};
            end
            valid_d = {DEPTH{1'b0}};
            count_d = CW'(0);
        end else if (!en) begin
            count_d = count_q;
        end else if (accept) begin
            data_d[0]  = (pos == CW'(0)) ? in_data : pp_data[0];
            valid_d[0] = (pos == CW'(0)) ? 1'b1 : pp_valid[0];
            for (int i = 1; i < DEPTH; i++) begin
                if (CW'(i) < pos) begin
                    data_d[i]  = pp_data[i];
                    valid_d[i] = pp_valid[i];
                end else if (CW'(i) == pos) begin
                    data_d[i]  = in_data;
                    valid_d[i] = 1'b1;
                end else begin
                    data_d[i]  = pp_data[i-1];
                    valid_d[i] = pp_valid[i-1];
                end
            end
            count_d = pop_eff ? count_q : (count_q + CW'(1));
        end else begin
            data_d  = pp_data;
            valid_d = pp_valid;
            count_d = pp_count;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {WIDTH{1'b0}};
            end
            valid_q <= {DEPTH{1'b0}};
            count_q <= CW'(0);
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign head_data  = data_q[0];
    assign head_valid = valid_q[0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign all_data[g*WIDTH +: WIDTH] = data_q[g];
    end
endmodule

// File: tb/tb_sorted_reg_bank.sv
// Self-checking bench for sorted_reg_bank: an ascending and a descending instance share one stimulus stream
// and are compared against queue-based reference models.
module tb_sorted_reg_bank;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, clr, in_valid, pop;
    logic [W-1:0] in_data;

    logic          rdy_a, hv_a, full_a, empty_a;
    logic [W-1:0]  head_a;
    logic [CW-1:0] cnt_a;
    logic [W*D-1:0] all_a;
    logic          rdy_d, hv_d, full_d, empty_d;
    logic [W-1:0]  head_d;
    logic [CW-1:0] cnt_d;
    logic [W*D-1:0] all_d;

    int checks   = 0;
    int failures = 0;

    typedef struct {int val; int tag;} ent_t;
    typedef ent_t q_t[$];
    q_t qa;
    q_t qd;
    int tag_ctr = 0;

    sorted_reg_bank #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .pop(pop), .head_data(head_a), .head_valid(hv_a), .count(cnt_a),
        .full(full_a), .empty(empty_a), .all_data(all_a));

    sorted_reg_bank #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b1)) dut_d (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(rdy_d),
        .in_data(in_data), .pop(pop), .head_data(head_d), .head_valid(hv_d), .count(cnt_d),
        .full(full_d), .empty(empty_d), .all_data(all_d));

    // Reference: sorted list; pop removes the front, insert goes before the first strictly-later value.
    function automatic q_t model_step(q_t q, bit desc, bit v, int d, bit p, bit e, bit c, int tag);
        q_t r;
        int ins;
        bit ready;
        r = q;
        if (c) begin
            r.delete();
        end else if (e) begin
            ready = (r.size() < D) || p;
            if (p && r.size() > 0) r.delete(0);
            if (v && ready) begin
                ins = r.size();
                for (int i = 0; i < r.size(); i++) begin
                    if (desc ? (d > r[i].val) : (d < r[i].val)) begin
                        ins = i;
                        break;
                    end
                end
                r.insert(ins, '{val: d, tag: tag});
            end
        end
        return r;
    endfunction

    function automatic logic [W*D-1:0] pack(q_t q);
        logic [W*D-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < q.size(); i++) begin
            v = q[i].val;
            r[i*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_head(q_t q);
        int v;
        v = (q.size() > 0) ? q[0].val : 0;
        return v[W-1:0];
    endfunction

    task automatic drive(bit v, int d, bit p, bit e, bit c);
        in_valid = v;
        in_data  = d[W-1:0];
        pop      = p;
        en       = e;
        clr      = c;
        #1;
    endtask

    task automatic tick();
        bit acc;
        acc = !rst && !clr && en && in_valid && ((qa.size() < D) || pop);
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qd.delete();
        end else begin
            qa = model_step(qa, 1'b0, in_valid, int'(in_data), pop, en, clr, tag_ctr);
            qd = model_step(qd, 1'b1, in_valid, int'(in_data), pop, en, clr, tag_ctr);
        end
        if (acc) tag_ctr++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (cnt_a !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        checks++; if (empty_a !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_a); end
        checks++; if (hv_a !== 1'b0) begin failures++; $display("FAIL reset_head_valid got=%b exp=0", hv_a); end
        checks++; if (all_a !== '0 || all_d !== '0) begin failures++; $display("FAIL reset_all_data got=%h/%h exp=0", all_a, all_d); end
        checks++; if (rdy_a !== 1'b1 || full_a !== 1'b0) begin failures++; $display("FAIL reset_ready_full got=%b/%b exp=1/0", rdy_a, full_a); end
    endtask

    task automatic test_ascending();
        int vals[5] = '{9, 3, 12, 3, 0};
        foreach (vals[i]) begin
            drive(1'b1, vals[i], 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (all_a !== 32'h000C9330) begin failures++; $display("FAIL asc_all_data got=%h exp=000c9330", all_a); end
        checks++; if (cnt_a !== CW'(5)) begin failures++; $display("FAIL asc_count got=%0d exp=5", cnt_a); end
        checks++; if (head_a !== 4'd0 || hv_a !== 1'b1) begin failures++; $display("FAIL asc_head got=%0d/%b exp=0/1", head_a, hv_a); end
        checks++; if (all_d !== pack(qd)) begin failures++; $display("FAIL asc_desc_all got=%h exp=%h", all_d, pack(qd)); end
    endtask

    task automatic test_fill_stream();
        int vals[3] = '{7, 15, 1};
        foreach (vals[i]) begin
            drive(1'b1, vals[i], 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 5, 1'b1, 1'b1, 1'b0);
        checks++; if (full_a !== 1'b1 || cnt_a !== CW'(D)) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/8", full_a, cnt_a); end
        checks++; if (rdy_a !== 1'b1 || rdy_d !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b/%b exp=1/1", rdy_a, rdy_d); end
        tick();
        checks++; if (all_a !== 32'hFC975331) begin failures++; $display("FAIL stream_all_a got=%h exp=fc975331", all_a); end
        checks++; if (all_d !== pack(qd) || cnt_a !== CW'(D)) begin failures++; $display("FAIL stream_all_d got=%h/%0d exp=%h/8", all_d, cnt_a, pack(qd)); end
        drive(1'b1, 2, 1'b0, 1'b1, 1'b0);
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", rdy_a); end
        tick();
        checks++; if (all_a !== pack(qa) || all_d !== pack(qd)) begin failures++; $display("FAIL full_hold got=%h/%h exp=%h/%h", all_a, all_d, pack(qa), pack(qd)); end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
            tick();
            checks++;
            if (head_a !== exp_head(qa) || head_d !== exp_head(qd) || cnt_a !== CW'(qa.size())) begin
                failures++;
                $display("FAIL drain_head k=%0d got=%0d/%0d cnt=%0d exp=%0d/%0d cnt=%0d", k, head_a, head_d, cnt_a,
                         exp_head(qa), exp_head(qd), qa.size());
            end
            if (k == 7) begin
                checks++; if (empty_a !== 1'b1 || hv_a !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty_a, hv_a); end
            end
        end
        checks++; if (cnt_a !== CW'(0) || cnt_d !== CW'(0) || all_a !== '0) begin failures++; $display("FAIL drain_extra_pop got=%0d/%0d exp=0/0", cnt_a, cnt_d); end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, int'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, int'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL en0_ready got=%b exp=0", rdy_a); end
        tick();
        checks++; if (all_a !== pack(qa) || all_d !== pack(qd) || cnt_a !== CW'(4)) begin failures++; $display("FAIL en0_hold got=%h/%0d exp=%h/4", all_a, cnt_a, pack(qa)); end
        drive(1'b1, 3, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (cnt_a !== CW'(0) || all_a !== '0 || all_d !== '0) begin failures++; $display("FAIL clr_en0 got=%0d/%h exp=0/0", cnt_a, all_a); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 6 + k, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (cnt_a !== CW'(2)) begin failures++; $display("FAIL pre_rst_count got=%0d exp=2", cnt_a); end
        rst = 1'b1;
        #1;
        qa.delete();
        qd.delete();
        checks++; if (cnt_a !== CW'(0) || all_a !== '0 || hv_a !== 1'b0 || all_d !== '0) begin failures++; $display("FAIL async_rst got=%0d/%h/%b exp=0/0/0", cnt_a, all_a, hv_a); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_descend();
        int vals[3] = '{2, 15, 7};
        foreach (vals[i]) begin
            drive(1'b1, vals[i], 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (all_d !== 32'h0000027F || cnt_d !== CW'(3)) begin failures++; $display("FAIL desc_all got=%h/%0d exp=0000027f/3", all_d, cnt_d); end
        tick();
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (head_d !== 4'd7 || cnt_d !== CW'(2)) begin failures++; $display("FAIL desc_pop got=%0d/%0d exp=7/2", head_d, cnt_d); end
        checks++; if (all_a !== pack(qa)) begin failures++; $display("FAIL desc_asc_all got=%h exp=%h", all_a, pack(qa)); end
    endtask

    task automatic test_random();
        bit v, p, e, c, er;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 39) == 0);
            drive(v, int'($urandom_range(0, 15)), p, e, c);
            er = e && ((qa.size() < D) || p);
            checks++; if (rdy_a !== er || rdy_d !== er) begin failures++; $display("FAIL rand_ready n=%0d got=%b/%b exp=%b", n, rdy_a, rdy_d, er); end
            tick();
            checks++;
            if (all_a !== pack(qa) || all_d !== pack(qd)) begin
                failures++;
                $display("FAIL rand_all n=%0d got=%h/%h exp=%h/%h", n, all_a, all_d, pack(qa), pack(qd));
            end
            checks++;
            if (cnt_a !== CW'(qa.size()) || full_a !== (qa.size() == D) || empty_a !== (qa.size() == 0) ||
                cnt_d !== CW'(qd.size()) || full_d !== (qd.size() == D) || empty_d !== (qd.size() == 0)) begin
                failures++;
                $display("FAIL rand_count n=%0d got=%0d/%0d f=%b e=%b exp=%0d", n, cnt_a, cnt_d, full_a, empty_a, qa.size());
            end
            checks++;
            if (head_a !== exp_head(qa) || hv_a !== (qa.size() > 0) || head_d !== exp_head(qd) || hv_d !== (qd.size() > 0)) begin
                failures++;
                $display("FAIL rand_head n=%0d got=%0d/%0d exp=%0d/%0d", n, head_a, head_d, exp_head(qa), exp_head(qd));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; pop = 1'b0; in_data = '0;
        test_reset();
        test_ascending();
        test_fill_stream();
        test_drain();
        test_priority();
        test_descend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sorted_reg_bank.md
Name: sorted_reg_bank

Overview:
- Parametrised successor to the single enabled hold register: a bank of DEPTH registers, each WIDTH bits wide, that keeps its contents sorted on every insert.
- Values enter one per cycle through a valid/ready port and are placed directly in sorted position (single-cycle insertion sort).
- The head value, which is the minimum, or the maximum when DESCEND=1, can be popped.
- It is the storage element of the proto_sort datapath, between the input capture registers and the output sequencer.

Parameters:
- WIDTH, 4: bit width of each stored value (unsigned).
- DEPTH, 8: number of entries; must be >= 2.
- DESCEND, 0: 0 = ascending (entry 0 is the smallest); 1 = descending (entry 0 is the largest).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when 0, bank state is frozen.
- clr  in  1  synchronous clear of all entries.
- in_valid  in  1  in_data is offered for insertion.
- in_ready  out  1  bank can accept in_data this cycle.
- in_data  in  WIDTH  value to insert.
- pop  in  1  remove entry 0 this cycle.
- head_data  out  WIDTH  entry 0; 0 when the bank is empty.
- head_valid  out  1  entry 0 holds valid data.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- all_data  out  WIDTH*DEPTH  flattened entries; entry i occupies bits [i*WIDTH +: WIDTH]; invalid entries read 0.

Behaviour:
- State: DEPTH data registers, DEPTH valid bits (always a contiguous run from entry 0), and count. All registers update on posedge clk and are cleared on posedge rst.
- Reset (async): all entries = 0, all valids = 0, count = 0. Outputs after reset: empty = 1, full = 0, head_valid = 0, head_data = 0, all_data = 0, in_ready = 1 when en = 1.
- Priority per cycle: rst, then clr, then en = 0 (hold), then pop/insert.
- clr = 1 with en = 1: same result as reset on the next edge; in_valid and pop are ignored that cycle.
- clr = 1 with en = 0: also clears; clr is independent of en.
- en = 0: every register holds its value, and in_ready = 0.
- accept = in_valid & in_ready.
- in_ready = en & (!full | pop).
- pop_eff = pop & en & !empty. A pop on an empty bank is ignored, with no error.
- Insert position, ascending: the first index i among the remaining valid entries with in_data < entry[i]. If no such index exists, the value goes at index = remaining count.
- Insert position, descending: the same rule with ">" instead of "<".
- Ties are stable: a new value is placed after existing equal values.
- Insert only: entries at index >= position shift up by one; in_data is written at the position; count increments.
- Pop only: every entry shifts down by one; the top valid entry is cleared to 0 and its valid bit to 0; count decrements.
- Pop and insert in the same cycle: the pop is applied first, then the insert is computed against the post-pop contents, all in one edge; count is unchanged. This is allowed when full, and is how a full bank streams.
- Latency: an accepted value is visible on all_data, head_data and count one cycle after the accepting edge. The outputs are direct register/decode outputs and are never combinationally dependent on in_data.
- in_ready depends combinationally on pop; the upstream block must not make pop depend on in_ready.
- Full with in_valid = 1 and pop = 0: no accept, and contents are unchanged.
- Count never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-operation: contents are lost immediately, without waiting for a clock edge.
- Compare and shift logic is generated for any DEPTH; there are no hard-coded widths.

Test Plan:
1. Reset then idle: hold rst high for 2 cycles, then release -> count = 0, empty = 1, head_valid = 0, all_data = 0, in_ready = 1.
2. Ascending insert, WIDTH = 4, DEPTH = 8: insert 9, 3, 12, 3, 0 on consecutive cycles -> all_data entries 0..4 = 0, 3, 3, 9, 12; count = 5; head_data = 0. Check the ties are stable by using a tagged variant in the bench model.
3. Fill and stream: insert 8 values until full = 1. Then insert 5 with pop = 1 in the same cycle -> old head removed, 5 placed in order, count stays 8. Then insert with pop = 0 -> in_ready = 0 and contents unchanged.
4. Drain: pop on 9 consecutive cycles from full -> head values come out in ascending order; after the 8th pop empty = 1; the 9th pop is ignored and count stays 0.
5. Control priority: with 4 entries held, drop en to 0 and drive in_valid = 1, pop = 1 -> no change. Then assert clr with en = 0 -> cleared next edge. Assert rst asynchronously between edges -> outputs drop to 0 immediately.
6. DESCEND = 1 instance: insert 2, 15, 7 -> entries 15, 7, 2; pop -> head_data = 7, count = 2.
